// File: rtl/score_digit_sequencer.sv
// Converts the game score into committed hundreds/tens/ones digit indices once per frame.
// Latency: the commit edge is E0+H+T+3 after the frame_start sampling edge E0, so 3..21 edges.
// Backpressure: none. frame_start is ignored unless idle, and committed outputs hold between commits.
module score_digit_sequencer #(
  parameter int SCORE_WIDTH = 32,
  parameter int MAX_DISPLAY = 999
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic                   frame_start,
  output logic [3:0]             hundreds,
  output logic [3:0]             tens,
  output logic [3:0]             ones,
  output logic                   show_hundreds,
  output logic                   show_tens,
  output logic                   overflow,
  output logic                   busy,
  output logic                   update_done
);

  // The saturation limit is used at full score width for the compare and at 10 bits as a remainder.
  localparam logic [SCORE_WIDTH-1:0] MAX_FULL = SCORE_WIDTH'(MAX_DISPLAY);
  localparam logic [9:0]             MAX_REM  = 10'(MAX_DISPLAY);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_HUND = 2'd1,
    TENS      = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] rem_q, rem_d;
  logic [3:0] h_work_q, h_work_d;
  logic [3:0] t_work_q, t_work_d;
  logic       ovf_work_q, ovf_work_d;

  logic [3:0] hundreds_q, hundreds_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       show_hundreds_q, show_hundreds_d;
  logic       show_tens_q, show_tens_d;
  logic       overflow_q, overflow_d;
  logic       busy_q, busy_d;
  logic       update_done_q, update_done_d;

  // Next-state and datapath: digits are found by repeated subtraction, one step per cycle.
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    h_work_d        = h_work_q;
    t_work_d        = t_work_q;
    ovf_work_d      = ovf_work_q;
    hundreds_d      = hundreds_q;
    tens_d          = tens_q;
    ones_d          = ones_q;
    show_hundreds_d = show_hundreds_q;
    show_tens_d     = show_tens_q;
    overflow_d      = overflow_q;
    update_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          // Score is sampled only here; later changes cannot disturb the conversion.
          if (score > MAX_FULL) begin
            rem_d      = MAX_REM;
            ovf_work_d = 1'b1;
          end else begin
            rem_d      = score[9:0];
            ovf_work_d = 1'b0;
          end
          h_work_d = 4'd0;
          t_work_d = 4'd0;
          state_d  = LOAD_HUND;
        end
      end
      LOAD_HUND: begin
        if (rem_q >= 10'd100) begin
          rem_d    = rem_q - 10'd100;
          h_work_d = h_work_q + 4'd1;
        end else begin
          state_d = TENS;
        end
      end
      TENS: begin
        if (rem_q >= 10'd10) begin
          rem_d    = rem_q - 10'd10;
          t_work_d = t_work_q + 4'd1;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        // Whole digit set moves at once so the renderer never sees a mixed frame.
        hundreds_d      = h_work_q;
        tens_d          = t_work_q;
        ones_d          = rem_q[3:0];
        overflow_d      = ovf_work_q;
        show_hundreds_d = (h_work_q != 4'd0);
        show_tens_d     = (h_work_q != 4'd0) || (t_work_q != 4'd0);
        update_done_d   = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, working registers and committed outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rem_q           <= 10'd0;
      h_work_q        <= 4'd0;
      t_work_q        <= 4'd0;
      ovf_work_q      <= 1'b0;
      hundreds_q      <= 4'd0;
      tens_q          <= 4'd0;
      ones_q          <= 4'd0;
      show_hundreds_q <= 1'b0;
      show_tens_q     <= 1'b0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
      update_done_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      h_work_q        <= h_work_d;
      t_work_q        <= t_work_d;
      ovf_work_q      <= ovf_work_d;
      hundreds_q      <= hundreds_d;
      tens_q          <= tens_d;
      ones_q          <= ones_d;
      show_hundreds_q <= show_hundreds_d;
      show_tens_q     <= show_tens_d;
      overflow_q      <= overflow_d;
      busy_q          <= busy_d;
      update_done_q   <= update_done_d;
    end
  end

  assign hundreds      = hundreds_q;
  assign tens          = tens_q;
  assign ones          = ones_q;
  assign show_hundreds = show_hundreds_q;
  assign show_tens     = show_tens_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;
  assign update_done   = update_done_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Bench for score_digit_sequencer: decimal reference model computed with / and %.
// Drives and samples on the falling clock edge.
// Covers reset, latency, saturation, digit boundaries, interference, stability and random scores.
module tb_score_digit_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] score;
  logic        frame_start;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic        show_hundreds;
  logic        show_tens;
  logic        overflow;
  logic        busy;
  logic        update_done;

  int total = 0;
  int bad   = 0;

  score_digit_sequencer #(.SCORE_WIDTH(32), .MAX_DISPLAY(999)) dut (
    .clk          (clk),
    .reset        (reset),
    .score        (score),
    .frame_start  (frame_start),
    .hundreds     (hundreds),
    .tens         (tens),
    .ones         (ones),
    .show_hundreds(show_hundreds),
    .show_tens    (show_tens),
    .overflow     (overflow),
    .busy         (busy),
    .update_done  (update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed committed outputs packed as {h, t, o, show_h, show_t, ovf}.
  logic [14:0] obs;
  assign obs = {hundreds, tens, ones, show_hundreds, show_tens, overflow};

  // Reference: saturate, then split into decimal digits arithmetically.
  function automatic logic [14:0] exp_vec(input logic [31:0] s);
    int v, h, t, o;
    v = (s > 32'd999) ? 999 : int'(s);
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {4'(h), 4'(t), 4'(o), (h != 0), (v >= 10), (s > 32'd999)};
  endfunction

  function automatic int exp_lat(input logic [31:0] s);
    int v;
    v = (s > 32'd999) ? 999 : int'(s);
    return (v / 100) + ((v / 10) % 10) + 3;
  endfunction

  // Starts a conversion and returns edges from E0 to the commit edge, or -1 on timeout.
  // Returns at the falling edge where update_done is first seen high.
  task automatic do_conv(input logic [31:0] s, output int lat);
    @(negedge clk);
    score       = s;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (update_done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1; score = 32'd0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({obs, busy, update_done} !== 17'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {obs, busy, update_done});
    end
    reset = 1'b0;
    do_conv(32'd857, lat);
    total++;
    if (obs !== exp_vec(32'd857)) begin
      bad++; $display("FAIL pre_reset_commit got=%h exp=%h", obs, exp_vec(32'd857));
    end
    // Abort a conversion mid-flight; clear must be immediate, not on a clock edge.
    @(negedge clk);
    score = 32'd999; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({obs, busy, update_done} !== 17'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=0", {obs, busy, update_done});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    total++;
    if ({obs, update_done} !== 16'd0) begin
      bad++; $display("FAIL aborted_no_commit got=%h exp=0", {obs, update_done});
    end
    do_conv(32'd57, lat);
    total++;
    if (obs !== exp_vec(32'd57) || lat !== exp_lat(32'd57)) begin
      bad++; $display("FAIL reset_then_57 got=%h lat=%0d exp=%h lat=%0d", obs, lat, exp_vec(32'd57), exp_lat(32'd57));
    end
    @(negedge clk);
    total++;
    if (update_done !== 1'b0) begin
      bad++; $display("FAIL update_done_width got=%b exp=0", update_done);
    end
  endtask

  task automatic test_zero_latency();
    int lat;
    @(negedge clk);
    score = 32'd0; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_after_start got=%b exp=1", busy);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (update_done) begin lat = n; break; end
    end
    total++;
    if (lat !== 3 || obs !== exp_vec(32'd0)) begin
      bad++; $display("FAIL zero_latency got lat=%0d obs=%h exp lat=3 obs=%h", lat, obs, exp_vec(32'd0));
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_after_commit got=%b exp=0", busy);
    end
  endtask

  task automatic test_max_saturation();
    int lat;
    do_conv(32'd999, lat);
    total++;
    if (lat !== 21 || obs !== exp_vec(32'd999)) begin
      bad++; $display("FAIL max_999 got lat=%0d obs=%h exp lat=21 obs=%h", lat, obs, exp_vec(32'd999));
    end
    do_conv(32'h0000_1234, lat);
    total++;
    if (lat !== 21 || obs !== {4'd9, 4'd9, 4'd9, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL saturate_1234 got lat=%0d obs=%h exp lat=21 obs=%h", lat, obs, {4'd9, 4'd9, 4'd9, 3'b111});
    end
    do_conv(32'd1000, lat);
    total++;
    if (obs !== exp_vec(32'd1000)) begin
      bad++; $display("FAIL saturate_1000 got=%h exp=%h", obs, exp_vec(32'd1000));
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] tbl [6];
    int lat;
    tbl = '{32'd9, 32'd10, 32'd99, 32'd100, 32'd101, 32'd990};
    foreach (tbl[i]) begin
      do_conv(tbl[i], lat);
      total++;
      if (obs !== exp_vec(tbl[i]) || lat !== exp_lat(tbl[i])) begin
        bad++; $display("FAIL boundary_%0d got=%h lat=%0d exp=%h lat=%0d", tbl[i], obs, lat, exp_vec(tbl[i]), exp_lat(tbl[i]));
      end
    end
  endtask

  task automatic test_interference();
    int pulses;
    logic [14:0] at_pulse;
    @(negedge clk);
    score = 32'd742; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    pulses = 0; at_pulse = '0;
    @(negedge clk);
    score = 32'd5; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (update_done) begin pulses++; at_pulse = obs; end
    end
    total++;
    if (pulses !== 1 || at_pulse !== exp_vec(32'd742)) begin
      bad++; $display("FAIL interference got pulses=%0d obs=%h exp pulses=1 obs=%h", pulses, at_pulse, exp_vec(32'd742));
    end
    total++;
    if (obs !== exp_vec(32'd742)) begin
      bad++; $display("FAIL interference_hold got=%h exp=%h", obs, exp_vec(32'd742));
    end
  endtask

  task automatic test_stability(input logic [31:0] last);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      score = $urandom;
      total++;
      if (obs !== exp_vec(last) || update_done !== 1'b0) begin
        bad++; $display("FAIL stability_%0d got=%h upd=%b exp=%h upd=0", n, obs, update_done, exp_vec(last));
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    @(negedge clk);
    score = 32'd0; frame_start = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (update_done) pulses++;
    end
    frame_start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (pulses !== 4 || obs !== exp_vec(32'd0)) begin
      bad++; $display("FAIL back_to_back got pulses=%0d obs=%h exp pulses=4 obs=%h", pulses, obs, exp_vec(32'd0));
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    int lat;
    for (int n = 0; n < 25; n++) begin
      s = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
      do_conv(s, lat);
      total++;
      if (obs !== exp_vec(s) || lat !== exp_lat(s)) begin
        bad++; $display("FAIL random_%0d score=%0d got=%h lat=%0d exp=%h lat=%0d", n, s, obs, lat, exp_vec(s), exp_lat(s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_max_saturation();
    test_boundaries();
    test_interference();
    test_stability(32'd742);
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
